// File: rtl/boot_port_mux.sv
// boot_port_mux: arbitrates NUM_PORTS byte-stream host ports onto one bootloader stream pair.
// Define BOOT_PORT_RELEASE_EN to drop an idle lock after IDLE_TIMEOUT cycles.
module boot_port_mux #(
    parameter int NUM_PORTS    = 3,
    parameter int DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] MAGIC_BYTE = 8'hbc,
    parameter int DEFAULT_PORT = NUM_PORTS-1,
    parameter int IDLE_TIMEOUT = 12000000,
    localparam int PW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             port_rx_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_rx_data,
    output logic [NUM_PORTS-1:0]             port_rx_ready,
    input  logic [NUM_PORTS-1:0]             port_rx_break,
    output logic [NUM_PORTS-1:0]             port_tx_valid,
    output logic [DATA_WIDTH-1:0]            port_tx_data,
    input  logic [NUM_PORTS-1:0]             port_tx_ready,
    output logic [NUM_PORTS-1:0]             port_tx_enable,
    output logic                             bl_in_valid,
    output logic [DATA_WIDTH-1:0]            bl_in_data,
    input  logic                             bl_in_ready,
    input  logic                             bl_out_valid,
    input  logic [DATA_WIDTH-1:0]            bl_out_data,
    output logic                             bl_out_ready,
    input  logic                             bl_busy,
    output logic                             bl_reset,
    output logic                             locked,
    output logic [PW-1:0]                    active_port
);

    localparam logic [PW-1:0] DFLT = PW'(DEFAULT_PORT);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] port_q, port_d;
    logic          pend_q, pend_d;
    logic [PW-1:0] pend_idx_q, pend_idx_d;
    logic          rst_q;
    logic          take, brk_sel, hit, tx_stall;
    logic [PW-1:0] hit_idx;

    // Never switch owner while a TX byte is offered but not yet taken.
    assign tx_stall = bl_out_valid & ~bl_out_ready;

    // Magic scan on non-default ports; descending loop leaves the lowest index.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_PORTS-1; k >= 0; k--) begin
            if (k != DEFAULT_PORT && port_rx_valid[k] &&
                port_rx_data[k*DATA_WIDTH +: DATA_WIDTH] == MAGIC_BYTE) begin
                hit     = 1'b1;
                hit_idx = PW'(k);
            end
        end
    end

`ifdef BOOT_PORT_RELEASE_EN
    localparam int CW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    logic [CW-1:0] idle_cnt;
    logic          idle_act, idle_expired;

    assign idle_act     = (bl_in_valid & bl_in_ready) | bl_busy | bl_out_valid;
    assign idle_expired = (state_q == LOCKED) & ~idle_act &
                          (idle_cnt == CW'(IDLE_TIMEOUT-1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            idle_cnt <= '0;
        else if (state_q != LOCKED || idle_act || idle_expired)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    logic unused_busy;
    assign unused_busy = bl_busy;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= UNLOCKED;
            port_q     <= DFLT;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            rst_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            rst_q      <= take | brk_sel;
        end
    end

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        pend_d     = pend_q;
        pend_idx_d = pend_idx_q;
        take       = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (pend_q || hit) begin
                    if (tx_stall) begin
                        pend_d     = 1'b1;
                        pend_idx_d = pend_q ? pend_idx_q : hit_idx;
                    end else begin
                        state_d = LOCKED;
                        port_d  = pend_q ? pend_idx_q : hit_idx;
                        pend_d  = 1'b0;
                        take    = 1'b1;
                    end
                end
            end
            LOCKED: begin
`ifdef BOOT_PORT_RELEASE_EN
                if (idle_expired) begin
                    state_d = UNLOCKED;
                    port_d  = DFLT;
                end
`endif
            end
            default: state_d = UNLOCKED;
        endcase
    end

    // Zero-latency routing around the owning port; unselected RX is sunk.
    always_comb begin
        bl_in_valid    = 1'b0;
        bl_in_data     = '0;
        bl_out_ready   = 1'b0;
        brk_sel        = 1'b0;
        port_rx_ready  = '1;
        port_tx_valid  = '0;
        port_tx_enable = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (PW'(k) == port_q) begin
                bl_in_valid       = port_rx_valid[k];
                bl_in_data        = port_rx_data[k*DATA_WIDTH +: DATA_WIDTH];
                port_rx_ready[k]  = bl_in_ready;
                port_tx_valid[k]  = bl_out_valid;
                port_tx_enable[k] = 1'b1;
                bl_out_ready      = port_tx_ready[k];
                brk_sel           = port_rx_break[k];
            end
        end
    end

    assign port_tx_data = bl_out_data;
    assign bl_reset     = rst_q;
    assign locked       = (state_q == LOCKED);
    assign active_port  = port_q;

endmodule

// File: doc/boot_port_mux.md
Name: boot_port_mux

Overview:
- Parametrised successor to the fixed two-UART/one-I2C routing in front of spi_bootloader.
- Arbitrates NUM_PORTS byte-stream host ports onto the single bootloader data_in/data_out pair.
- A port claims the bootloader by sending MAGIC_BYTE; it is then locked, and the block can optionally release it after inactivity.
- Also generates the bootloader reset pulse and per-port TX-enable, used for tristating shared pins.

Parameters:
NUM_PORTS, 3, number of host ports (≥2)
DATA_WIDTH, 8, byte width of every stream
MAGIC_BYTE, 8'hbc, claim byte for non-default ports
DEFAULT_PORT, NUM_PORTS-1, port routed while unlocked; never needs magic (I2C-style)
IDLE_TIMEOUT, 12000000, release timeout in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
port_rx_valid  in  NUM_PORTS  per-port RX byte valid
port_rx_data  in  NUM_PORTS*DATA_WIDTH  RX bytes, port k at [k*DATA_WIDTH +: DATA_WIDTH]
port_rx_ready  out  NUM_PORTS  per-port RX ready
port_rx_break  in  NUM_PORTS  per-port break/reset request, 1-cycle pulse
port_tx_valid  out  NUM_PORTS  per-port TX valid
port_tx_data  out  DATA_WIDTH  shared TX byte
port_tx_ready  in  NUM_PORTS  per-port TX ready
port_tx_enable  out  NUM_PORTS  per-port pin drive enable
bl_in_valid / bl_in_data / bl_in_ready  out/out/in  1/DATA_WIDTH/1  stream to bootloader
bl_out_valid / bl_out_data / bl_out_ready  in/in/out  1/DATA_WIDTH/1  stream from bootloader
bl_busy  in  1  bootloader busy
bl_reset  out  1  bootloader reset pulse
locked  out  1  a non-default port owns the bootloader
active_port  out  PW  routed port index, PW = max(1,$clog2(NUM_PORTS))

Behaviour:
- Reset (reset_n low, async):
  - state=UNLOCKED, active_port=DEFAULT_PORT, locked=0, bl_reset=0, timeout counter=0.
  - port_tx_enable has only bit DEFAULT_PORT set.
- The datapath is combinational with zero latency. Only the lock state, bl_reset and the counter are registered.
- Routing, with s = active_port:
  - bl_in_valid = port_rx_valid[s]; bl_in_data = slice s.
  - port_rx_ready[s] = bl_in_ready. For every other port, port_rx_ready = 1 and its bytes are dropped after magic scanning.
  - port_tx_valid[k] = (k==s) & bl_out_valid. port_tx_data = bl_out_data. bl_out_ready = port_tx_ready[s].
- UNLOCKED:
  - Scan every non-default port k for port_rx_valid[k] & data==MAGIC_BYTE.
  - On a hit: next cycle state=LOCKED, active_port=k, locked=1, port_tx_enable=onehot(k), and bl_reset pulses for exactly 1 cycle.
  - The magic byte is consumed and is never forwarded.
  - Simultaneous hits: the lowest index wins; the others are dropped.
  - A hit is deferred while bl_out_valid & ~bl_out_ready, so a TX handshake is never switched mid-byte. The magic byte is still consumed and the lock is taken when the stall clears. A pending hit is held in a 1-bit register plus the port index.
  - port_rx_break[DEFAULT_PORT] → bl_reset pulse. Breaks on other ports are ignored.
  - MAGIC_BYTE arriving on DEFAULT_PORT is ordinary data.
- LOCKED:
  - Only port_rx_break[active_port] pulses bl_reset. Breaks from other ports and magic bytes on other ports are ignored.
  - The lock is permanent until reset_n, unless the optional feature releases it.
- bl_reset is a registered output: 1 cycle after the triggering event, 1 cycle wide. Back-to-back triggers give back-to-back pulses.

Optional Feature:
- Macro: BOOT_PORT_RELEASE_EN.
- With the macro, the counter runs only while LOCKED.
- Counter clears on:
  - any accepted RX byte on the locked port,
  - bl_busy=1,
  - bl_out_valid=1.
- When the count reaches IDLE_TIMEOUT-1, the next cycle returns to UNLOCKED, active_port=DEFAULT_PORT and port_tx_enable=onehot(DEFAULT_PORT). No bl_reset pulse is generated.
- Without the macro, the counter logic is absent and LOCKED is terminal.

Test Plan:
- After reset, default port 2 sends 0x11 → bl_in_data=0x11, locked=0, port_tx_enable=3'b100, bl_reset never asserts.
- Port 0 sends 0xbc → next cycle locked=1, active_port=0, port_tx_enable=3'b001, one-cycle bl_reset, 0xbc absent from bl_in. Then port 0 sends 0x42 → bl_in_data=0x42.
- Ports 0 and 1 send 0xbc in the same cycle → port 0 locks. Then port 1 sends 0xbc and break → no bl_reset, port_rx_ready[1]=1, no forwarding.
- Locked on port 1: bl_out 0x55 with port_tx_ready[1]=0 for 5 cycles → port_tx_valid=3'b010 held stable, bl_out_ready=0 until ready rises. Break on port 1 → single bl_reset pulse.
- Port 0 sends 0xbc while bl_out_valid is stalled on port 2 → lock is taken only in the cycle after the stall clears.
- BOOT_PORT_RELEASE_EN with IDLE_TIMEOUT=100: lock port 0, then idle with bl_busy=0 → unlocked at cycle 100 with no bl_reset. With bl_busy held at 1 → remains locked after 1000 cycles.
